// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 set-2 keyboard event path.
package kb_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Number of raw bytes that follow E1 in the Pause key sequence
  localparam int PAUSE_LEN = 7;

  localparam int EVT_W       = 10;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kb_state_t;

  // Packed so that ext lands on bit 9, brk on bit 8, code on bits 7:0
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  // Keyboard status / acknowledge bytes that never describe a key
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// Generic show-ahead FIFO: head entry is always visible, with occupancy
// count, full/empty flags and a one-cycle pulse when a push is dropped.
module kb_fifo #(
  parameter int W_SIZE = 2,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic [W_SIZE:0]   count,
  output logic              ovf_tick
);

  localparam int              DEPTH     = 1 << W_SIZE;
  localparam logic [W_SIZE:0] DEPTH_CNT = {1'b1, {W_SIZE{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [W_SIZE-1:0] wr_ptr;
  logic [W_SIZE-1:0] rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign pop_ok    = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the dropped-push pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_tick <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf_tick <= push && !push_ok;
    end
  end

endmodule

// File: rtl/kb_event_decoder.sv
// Turns the PS/2 receiver byte stream into key events {ext, brk, code}:
// decodes E0/F0/E1 prefixes, collapses the Pause sequence into one event,
// abandons stale prefixes after a timeout and queues events in a FIFO.
module kb_event_decoder
  import kb_pkg::*;
#(
  parameter int W_SIZE       = 2,
  parameter int REPORT_BREAK = 1,
  parameter int TIMEOUT      = 2_500_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_tick,
  input  logic [7:0]      scan_code,
  input  logic            rd_key,
  output logic [7:0]      key_code,
  output logic            key_ext,
  output logic            key_break,
  output logic            key_empty,
  output logic            key_full,
  output logic [W_SIZE:0] key_count,
  output logic            ovf_tick
);

  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  kb_state_t   state;
  kb_state_t   state_nxt;
  logic [2:0]  pause_cnt;
  logic [2:0]  pause_nxt;
  logic [31:0] timer;
  logic        timed_out;
  logic        push;
  kb_event_t   push_evt;
  logic [EVT_W-1:0] head;

  assign timed_out = (TIMEOUT != 0) && (state != ST_IDLE) && (timer == TO_LAST);

  // Byte decode: next state and the event pushed on the same edge as the byte
  always_comb begin
    state_nxt = state;
    pause_nxt = pause_cnt;
    push      = 1'b0;
    push_evt  = '0;
    if (scan_tick) begin
      if (state == ST_PAUSE) begin
        if (pause_cnt == 3'(PAUSE_LEN - 1)) begin
          push      = 1'b1;
          push_evt  = '{ext: 1'b0, brk: 1'b0, code: PFX_PAUSE};
          state_nxt = ST_IDLE;
          pause_nxt = '0;
        end else begin
          pause_nxt = pause_cnt + 1'b1;
        end
      end else if (scan_code == PFX_PAUSE) begin
        state_nxt = ST_PAUSE;
        pause_nxt = '0;
      end else if (scan_code == PFX_EXT) begin
        state_nxt = ST_EXT;
      end else if (scan_code == PFX_BRK) begin
        state_nxt = (state == ST_EXT || state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else if (is_ignored(scan_code)) begin
        state_nxt = ST_IDLE;
      end else begin
        push_evt.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
        push_evt.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
        push_evt.code = scan_code;
        push          = !push_evt.brk || (REPORT_BREAK != 0);
        state_nxt     = ST_IDLE;
      end
    end else if (timed_out) begin
      state_nxt = ST_IDLE;
      pause_nxt = '0;
    end
  end

  // Sequence state and Pause byte counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_nxt;
    end
  end

  // Cycles since the last byte while a prefix sequence is open
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (scan_tick || state == ST_IDLE || timed_out) begin
      timer <= '0;
    end else if (TIMEOUT != 0) begin
      timer <= timer + 1'b1;
    end
  end

  kb_fifo #(
    .W_SIZE (W_SIZE),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_evt),
    .pop       (rd_key),
    .head_data (head),
    .empty     (key_empty),
    .full      (key_full),
    .count     (key_count),
    .ovf_tick  (ovf_tick)
  );

  assign key_ext   = head[EVT_EXT_BIT];
  assign key_break = head[EVT_BRK_BIT];
  assign key_code  = head[7:0];

endmodule

// File: tb/tb_kb_event_decoder.sv
// Bench for kb_event_decoder: directed scenarios plus a randomized run
// against a byte-stream reference model with queue-based FIFOs.
module tb_kb_event_decoder;

  localparam int W_SIZE  = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            scan_tick;
  logic [7:0]      scan_code;
  logic            rd_key;

  logic [7:0]      key_code,  nb_code;
  logic            key_ext,   nb_ext;
  logic            key_break, nb_break;
  logic            key_empty, nb_empty;
  logic            key_full,  nb_full;
  logic [W_SIZE:0] key_count, nb_count;
  logic            ovf_tick,  nb_ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [9:0] q_rb[$];
  bit [9:0] q_nb[$];
  bit       exp_ovf;
  bit       exp_ovf_nb;
  bit       m_ext, m_brk;
  int       m_pause_left;
  int       m_gap;

  kb_event_decoder #(.W_SIZE(W_SIZE), .REPORT_BREAK(1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .scan_code(scan_code),
    .rd_key(rd_key), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_empty(key_empty), .key_full(key_full), .key_count(key_count), .ovf_tick(ovf_tick)
  );

  kb_event_decoder #(.W_SIZE(W_SIZE), .REPORT_BREAK(0), .TIMEOUT(TIMEOUT)) dut_nb (
    .clk(clk), .reset(reset), .scan_tick(scan_tick), .scan_code(scan_code),
    .rd_key(rd_key), .key_code(nb_code), .key_ext(nb_ext), .key_break(nb_break),
    .key_empty(nb_empty), .key_full(nb_full), .key_count(nb_count), .ovf_tick(nb_ovf)
  );

  always #5 clk = ~clk;

  function automatic bit ign(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE);
  endfunction

  task automatic model_reset();
    q_rb.delete();
    q_nb.delete();
    exp_ovf      = 1'b0;
    exp_ovf_nb   = 1'b0;
    m_ext        = 1'b0;
    m_brk        = 1'b0;
    m_pause_left = 0;
    m_gap        = 0;
  endtask

  // One clock edge of the model: interpret the byte, then apply pop/push
  task automatic model_edge(input bit tick, input logic [7:0] b, input bit rd);
    bit       has;
    bit [9:0] evt;
    bit       popped;
    has = 1'b0;
    evt = '0;
    if (tick) begin
      m_gap = 0;
      if (m_pause_left > 0) begin
        m_pause_left--;
        if (m_pause_left == 0) begin
          has = 1'b1;
          evt = {2'b00, 8'hE1};
        end
      end else if (b == 8'hE1) begin
        m_pause_left = 7;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext = 1'b1;
        m_brk = 1'b0;
      end else if (b == 8'hF0) begin
        m_brk = 1'b1;
      end else if (ign(b)) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else begin
        has   = 1'b1;
        evt   = {m_ext, m_brk, b};
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else if (m_ext || m_brk || m_pause_left > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        m_ext        = 1'b0;
        m_brk        = 1'b0;
        m_pause_left = 0;
        m_gap        = 0;
      end
    end else begin
      m_gap = 0;
    end

    popped = rd && (q_rb.size() > 0);
    if (popped) void'(q_rb.pop_front());
    exp_ovf = 1'b0;
    if (has) begin
      if (q_rb.size() < DEPTH) q_rb.push_back(evt);
      else exp_ovf = 1'b1;
    end

    popped = rd && (q_nb.size() > 0);
    if (popped) void'(q_nb.pop_front());
    exp_ovf_nb = 1'b0;
    if (has && !evt[8]) begin
      if (q_nb.size() < DEPTH) q_nb.push_back(evt);
      else exp_ovf_nb = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit tick, input logic [7:0] b, input bit rd);
    scan_tick = tick;
    scan_code = b;
    rd_key    = rd;
    @(posedge clk);
    model_edge(tick, b, rd);
    #1;
    scan_tick = 1'b0;
    scan_code = 8'h00;
    rd_key    = 1'b0;
  endtask

  task automatic applyReset();
    scan_tick = 1'b0;
    scan_code = 8'h00;
    rd_key    = 1'b0;
    reset     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    applyStimulus(1'b1, 8'h1C, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (key_empty !== 1'b1 || key_count !== 3'd0 || key_code !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: empty=%b count=%0d code=%h, want empty=1 count=0 code=00",
               key_empty, key_count, key_code);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checks++;
      if (ovf_tick !== 1'b0 || key_empty !== 1'b1 || key_full !== 1'b0 ||
          {key_ext, key_break, key_code} !== 10'h000) begin
        errors++;
        $display("[TB] FAIL reset_idle: ovf=%b empty=%b full=%b head=%h, want 0 1 0 000",
                 ovf_tick, key_empty, key_full, {key_ext, key_break, key_code});
      end
    end
  endtask

  task automatic test_break();
    applyReset();
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h01C || key_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL break_first: head=%h count=%0d, want 01C count=2",
               {key_ext, key_break, key_code}, key_count);
    end
    checks++;
    if ({nb_ext, nb_break, nb_code} !== 10'h01C || nb_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL nobreak_stored: head=%h count=%0d, want 01C count=1",
               {nb_ext, nb_break, nb_code}, nb_count);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h11C || nb_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_second: head=%h nb_empty=%b, want 11C nb_empty=1",
               {key_ext, key_break, key_code}, nb_empty);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++;
    if (key_empty !== 1'b1 || key_code !== 8'h00) begin
      errors++;
      $display("[TB] FAIL break_drained: empty=%b code=%h, want 1 00", key_empty, key_code);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [8];
    seq = '{8'hE0, 8'h75, 8'hFA, 8'hAA, 8'hE0, 8'hF0, 8'h75, 8'hAA};
    applyReset();
    foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b0);
    checks++;
    if (key_count !== 3'd2 || {key_ext, key_break, key_code} !== 10'h275) begin
      errors++;
      $display("[TB] FAIL ext_make: count=%0d head=%h, want 2 275",
               key_count, {key_ext, key_break, key_code});
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h375) begin
      errors++;
      $display("[TB] FAIL ext_break: head=%h, want 375", {key_ext, key_break, key_code});
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checks++;
    if (key_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ext_drained: empty=%b, want 1", key_empty);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    applyReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, seq[i], 1'b0);
    checks++;
    if (key_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL pause_partial: count=%0d, want 0", key_count);
    end
    applyStimulus(1'b1, seq[7], 1'b0);
    checks++;
    if (key_count !== 3'd1 || {key_ext, key_break, key_code} !== 10'h0E1) begin
      errors++;
      $display("[TB] FAIL pause_event: count=%0d head=%h, want 1 0E1",
               key_count, {key_ext, key_break, key_code});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] makes [5];
    logic [7:0] tail  [4];
    makes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    tail  = '{8'h1D, 8'h24, 8'h2D, 8'h35};
    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, makes[i], 1'b0);
      checks++;
      if (ovf_tick !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL ovf_pulse[%0d]: ovf=%b, want %b", i, ovf_tick, (i == 4));
      end
    end
    checks++;
    if (key_count !== 3'd4 || key_full !== 1'b1 || key_code !== 8'h15) begin
      errors++;
      $display("[TB] FAIL full_state: count=%0d full=%b code=%h, want 4 1 15",
               key_count, key_full, key_code);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checks++;
    if (ovf_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_single: ovf=%b, want 0", ovf_tick);
    end
    applyStimulus(1'b1, 8'h35, 1'b1);
    checks++;
    if (key_count !== 3'd4 || key_full !== 1'b1 || ovf_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL push_pop_full: count=%0d full=%b ovf=%b, want 4 1 0",
               key_count, key_full, ovf_tick);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (key_code !== tail[i]) begin
        errors++;
        $display("[TB] FAIL drain[%0d]: code=%h, want %h", i, key_code, tail[i]);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (key_empty !== 1'b1 || key_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_end: empty=%b full=%b, want 1 0", key_empty, key_full);
    end
  endtask

  task automatic test_timeout();
    applyReset();
    applyStimulus(1'b1, 8'hE0, 1'b0);
    repeat (TIMEOUT - 1) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h21C) begin
      errors++;
      $display("[TB] FAIL timeout_edge: head=%h, want 21C", {key_ext, key_break, key_code});
    end
    applyReset();
    applyStimulus(1'b1, 8'hE0, 1'b0);
    repeat (TIMEOUT) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h01C) begin
      errors++;
      $display("[TB] FAIL timeout_expired: head=%h, want 01C", {key_ext, key_break, key_code});
    end
    applyReset();
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checks++;
    if (key_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_midseq_empty: empty=%b, want 1", key_empty);
    end
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checks++;
    if ({key_ext, key_break, key_code} !== 10'h01C || key_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL reset_midseq_next: head=%h count=%0d, want 01C 1",
               {key_ext, key_break, key_code}, key_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] ign_codes [6];
    logic [7:0] b;
    bit         tick;
    bit         rd;
    int         gap;
    bit [9:0]   h_rb, h_nb;
    ign_codes = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    gap = 0;
    applyReset();
    for (int n = 0; n < 3000; n++) begin
      if (gap == 0 && $urandom_range(0, 59) == 0) gap = $urandom_range(12, 20);
      if (gap > 0) begin
        gap--;
        tick = 1'b0;
      end else begin
        tick = ($urandom_range(0, 1) == 1);
      end
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        3:       b = ign_codes[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(1, 255));
      endcase
      rd = ($urandom_range(0, 3) == 0);
      applyStimulus(tick, b, rd);
      h_rb = (q_rb.size() > 0) ? q_rb[0] : 10'h000;
      h_nb = (q_nb.size() > 0) ? q_nb[0] : 10'h000;
      checks++;
      if ({key_ext, key_break, key_code} !== h_rb || key_count !== 3'(q_rb.size()) ||
          key_empty !== (q_rb.size() == 0) || key_full !== (q_rb.size() == DEPTH)) begin
        errors++;
        $display("[TB] FAIL rand_fifo[%0d]: head=%h count=%0d empty=%b full=%b, want %h %0d %b %b",
                 n, {key_ext, key_break, key_code}, key_count, key_empty, key_full,
                 h_rb, q_rb.size(), (q_rb.size() == 0), (q_rb.size() == DEPTH));
      end
      checks++;
      if (ovf_tick !== exp_ovf) begin
        errors++;
        $display("[TB] FAIL rand_ovf[%0d]: ovf=%b, want %b", n, ovf_tick, exp_ovf);
      end
      checks++;
      if ({nb_ext, nb_break, nb_code} !== h_nb || nb_count !== 3'(q_nb.size()) ||
          nb_ovf !== exp_ovf_nb) begin
        errors++;
        $display("[TB] FAIL rand_nobreak[%0d]: head=%h count=%0d ovf=%b, want %h %0d %b",
                 n, {nb_ext, nb_break, nb_code}, nb_count, nb_ovf, h_nb, q_nb.size(), exp_ovf_nb);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    scan_tick = 1'b0;
    scan_code = 8'h00;
    rd_key    = 1'b0;
    model_reset();
    #12;
    test_reset();
    test_break();
    test_extended();
    test_pause();
    test_overflow();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
